fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Parametrised successor to the core's fetch subassembly.
- Owns the program counter and a writable jump-target LUT, and runs a start/done handshake with the testbench or host.
- Supports absolute and signed relative jumps, stall, explicit halt, a programmable end address and a cycle counter.
- Sits between the top-level handshake (req/done) and the instruction ROM, replacing the fixed PC + PC_LUT pair.

Parameters:
- D, 12, program counter width in bits.
- LW, 3, LUT index width; the LUT holds 2**LW entries of D bits.
- CW, 16, cycle counter width.
- START_ADDR, 0, PC value loaded at reset and at run start.
- END_ADDR, 30, PC value at which the run terminates.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request from host.
- stall  in  1  hold PC this cycle.
- halt  in  1  terminate run (decoded halt instruction).
- branch_en  in  1  take a jump this cycle.
- absjump_en  in  1  jump is absolute (PC <= LUT[lut_idx]).
- reljump_en  in  1  jump is relative (PC <= PC + LUT[lut_idx], two's complement).
- lut_idx  in  LW  LUT read index (instruction field).
- lut_we  in  1  LUT write enable.
- lut_waddr  in  LW  LUT write index.
- lut_wdata  in  D  LUT write data.
- prog_ctr  out  D  current PC, drives the instruction ROM.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- cycle_cnt  out  CW  cycles spent in RUN for the current or last run.

Behaviour:
- Reset (synchronous, active-high): state IDLE, prog_ctr = START_ADDR, cycle_cnt = 0, running = 0, done = 0, all LUT entries = 0. Reset wins over every other input, including mid-run.
- FSM states are IDLE, RUN and DONE. running and done are decoded from the registered state, so there is no combinational path from the inputs.
- IDLE:
  - prog_ctr holds.
  - If req = 1: next state RUN, prog_ctr <= START_ADDR, cycle_cnt <= 0.
- RUN, termination (priority order per edge):
  1. If halt = 1 or prog_ctr == END_ADDR: next state DONE, prog_ctr holds, cycle_cnt += 1. This is checked before stall and before branch.
  2. Otherwise, if stall = 1: prog_ctr holds, branch inputs are ignored, cycle_cnt += 1.
- RUN, PC update when not terminating and not stalled:
  - branch_en & absjump_en: prog_ctr <= LUT[lut_idx]. Absolute wins if both jump enables are set.
  - branch_en & reljump_en & ~absjump_en: prog_ctr <= (prog_ctr + LUT[lut_idx]) mod 2**D. The LUT entry is treated as signed D-bit, so wrap-around in both directions is legal.
  - branch_en with neither enable set: prog_ctr <= prog_ctr + 1.
  - Otherwise: prog_ctr <= prog_ctr + 1, with wrap from 2**D-1 to 0.
  - cycle_cnt += 1.
- cycle_cnt saturates at 2**CW-1; it never wraps.
- DONE:
  - prog_ctr and cycle_cnt hold; done = 1.
  - Stays in DONE while req = 1. When req = 0, next state IDLE and done drops on that edge.
  - A req that re-rises only after reaching IDLE starts a new run.
- LUT:
  - Written on the rising edge when lut_we = 1, in any state.
  - Read is combinational from lut_idx. A same-cycle read of the entry being written returns the old value; the new value is visible the next cycle.
- The branch/stall/halt inputs have no effect outside RUN.
- req is level-sensitive. Its deassertion during RUN does not abort the run.

Test Plan:
- Reset then req = 1 for 1 cycle, no branches, END_ADDR = 30:
  - PC steps 0, 1, …, 30; done rises the cycle after PC = 30 and PC holds at 30.
  - cycle_cnt = 31.
- Write LUT[2] = 12'd100. In RUN at PC = 5, assert branch_en + absjump_en with lut_idx = 2 -> next PC = 100. Assert both jump enables -> still 100 (absolute wins).
- Write LUT[1] = 12'hFFD (-3). At PC = 10, branch_en + reljump_en -> PC = 7. At PC = 1 -> PC = 0xFFE (wrap).
- stall = 1 for 3 cycles at PC = 4 with branch_en asserted -> PC stays 4 for 3 cycles and the branch is ignored. cycle_cnt still increments by 3.
- halt = 1 at PC = 9 while stall = 1 -> DONE next edge with PC = 9. Holding req = 1 keeps done = 1. req = 0 -> IDLE. A new req restarts at PC = 0 with cycle_cnt cleared.
- reset asserted mid-RUN at PC = 17 -> next edge: IDLE, PC = 0, cycle_cnt = 0, LUT reads 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, a writable jump-target LUT and
// the req/done run handshake. running/done come straight from the state
// register, so no input reaches them combinationally.
module fetch_sequencer #(
  parameter int D          = 12,
  parameter int LW         = 3,
  parameter int CW         = 16,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          absjump_en,
  input  logic          reljump_en,
  input  logic [LW-1:0] lut_idx,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  localparam int          DEPTH    = 2 ** LW;
  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  localparam logic [D-1:0] END_PC   = D'(END_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D-1:0]  lut_q [DEPTH];
  logic [D-1:0]  lut_rd;
  logic [CW-1:0] cnt_inc;

  // Combinational read: a same-edge write is only visible next cycle.
  assign lut_rd  = lut_q[lut_idx];
  // Saturating increment; the counter sticks at all-ones.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Jump-target LUT: cleared by reset, writable in any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  // State, PC and cycle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: termination beats stall, stall beats branch,
  // absolute beats relative.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (halt || (pc_q == END_PC)) begin
          state_d = S_DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch_en && absjump_en) begin
          pc_d = lut_rd;
        end else if (branch_en && reljump_en) begin
          // Two's-complement add wraps naturally in both directions.
          pc_d = pc_q + lut_rd;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!req) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign prog_ctr  = pc_q;
  assign cycle_cnt = cnt_q;
  assign running   = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule
